branch_predict_ctrl: RTL and testbench
======================================

// Module: branch_predict_ctrl
// PURPOSE
//  Branch controller for the 5-stage MIPS pipeline. Holds a 2-bit saturating
//  branch history table (BHT) that gives an IF-stage taken/not-taken guess for
//  BEQ/BNE, and resolves each branch in EX using the BEQ/BNE branch-code rules.
//  On a misprediction it redirects the PC and sequences an IF/ID + ID/EX flush.
// PARAMETERS
//  IDX_BITS      6   BHT index width; table depth = 2**IDX_BITS entries
//  FLUSH_CYCLES  2   cycles flush is held after a mispredict (1..7)
//  CNT_W         16  width of mispredict statistics counter
// PORTS
//  clock          in   1         system clock, rising edge
//  reset          in   1         synchronous, active-high
//  if_pc          in   32        PC of the instruction being fetched
//  pred_taken     out  1         BHT prediction for if_pc (combinational read)
//  stall_in       in   1         pipeline stall; EX contents are held
//  ex_valid       in   1         EX stage holds a valid instruction
//  ex_branch      in   2         00 none, 11 BEQ, 01 BNE, 10 treated as none
//  ex_zero        in   1         ALU zero flag of the EX compare
//  ex_pc          in   32        PC of the instruction in EX
//  ex_target      in   32        computed branch target of the EX branch
//  ex_pred_taken  in   1         prediction carried down the pipe with it
//  redirect       out  1         one-cycle pulse: load redirect_pc into PC
//  redirect_pc    out  32        corrected fetch address
//  flush          out  1         squash IF/ID and ID/EX registers
//  mispredict_cnt out  CNT_W     saturating count of mispredictions
// BEHAVIOUR
//  - idx(pc) = pc[IDX_BITS+1:2]; pred_taken = bht[idx(if_pc)][1].
//  - Branch resolved ("resolve") only when ex_valid=1, stall_in=0,
//    state=IDLE and ex_branch in {11,01}. Held branch under stall resolves once.
//  - actual = (11 & ex_zero) | (01 & ~ex_zero); mispredict = actual != ex_pred_taken.
//  - BHT update on resolve, visible cycle N+1: actual=1 -> +1 saturating at 3;
//    actual=0 -> -1 saturating at 0. Same-cycle read of the written entry
//    returns the OLD value (no bypass).
//  - Mispredict at cycle N: cycle N+1 redirect=1 for exactly one cycle,
//    redirect_pc = actual ? ex_target : ex_pc+4 (mod 2**32), flush=1.
//  - FSM: IDLE -> FLUSH on mispredict (load down-counter = FLUSH_CYCLES);
//    FLUSH: flush=1, counter decrements every cycle regardless of stall_in,
//    returns to IDLE after FLUSH_CYCLES cycles of flush. EX inputs ignored
//    in FLUSH (squashed instructions never update BHT or counter).
//  - Correct prediction: BHT updated only; no redirect, no flush.
//  - mispredict_cnt += 1 per mispredict, saturates at all-ones.
//  - Reset (any state, incl. mid-FLUSH): next cycle state=IDLE, redirect=0,
//    flush=0, redirect_pc=0, mispredict_cnt=0, every BHT entry=2'b01
//    (weakly not-taken), so pred_taken=0 after reset.
//  - ex_branch 00/10 never resolves, never touches BHT.
// TESTING
//  1 Reset, any if_pc -> pred_taken=0, flush=0, redirect=0, cnt=0.
//  2 BEQ pc=0x40, zero=1, pred=0, target=0x80 -> next cycle redirect=1,
//    redirect_pc=0x80; flush high 2 cycles; cnt=1; bht[16]=2, pred(0x40)=1.
//  3 BNE pc=0x44, zero=1, pred=1 -> redirect_pc=0x48, flush 2 cycles, bht[17]=0.
//  4 BEQ pc=0x40 taken 4x, correctly predicted after first -> counter sticks at 3,
//    no redirect after first, cnt=1.
//  5 Mispredict then valid BEQ in EX during FLUSH -> ignored: no BHT change,
//    cnt unchanged; stall_in=1 with branch held 3 cycles -> resolved once on release.
//  6 Reset asserted in 2nd flush cycle -> flush=0 next cycle, BHT back to 01.

Source files
------------

// File: rtl/branch_predict_ctrl.sv
// Branch controller: 2-bit saturating BHT for IF-stage prediction, EX-stage
// BEQ/BNE resolution, and PC redirect plus pipeline flush on a misprediction.
module branch_predict_ctrl #(
  parameter int unsigned IDX_BITS     = 6,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      if_pc,
  output logic             pred_taken,
  input  logic             stall_in,
  input  logic             ex_valid,
  input  logic [1:0]       ex_branch,
  input  logic             ex_zero,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_target,
  input  logic             ex_pred_taken,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic             flush,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int unsigned DEPTH = 1 << IDX_BITS;
  localparam int unsigned FC_W  = 3;

  typedef enum logic {S_IDLE = 1'b0, S_FLUSH = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [FC_W-1:0]     fcnt_q, fcnt_d;
  logic [1:0]          bht [DEPTH];

  logic                resolve, actual, mispredict;
  logic [IDX_BITS-1:0] ex_idx;
  logic [1:0]          bht_old, bht_new;
  logic                redirect_d, flush_d;
  logic [31:0]         redirect_pc_d;
  logic [CNT_W-1:0]    cnt_d;
  logic                unused_pc_bits;

  // Combinational prediction read; writes land on the next edge, so no bypass.
  assign pred_taken     = bht[if_pc[IDX_BITS+1:2]][1];
  assign ex_idx         = ex_pc[IDX_BITS+1:2];
  assign unused_pc_bits = ^{if_pc[31:IDX_BITS+2], if_pc[1:0]};

  // Branch resolution and counter update value.
  always_comb begin
    resolve    = ex_valid && !stall_in && (state_q == S_IDLE) &&
                 ((ex_branch == 2'b11) || (ex_branch == 2'b01));
    actual     = ((ex_branch == 2'b11) && ex_zero) ||
                 ((ex_branch == 2'b01) && !ex_zero);
    mispredict = resolve && (actual != ex_pred_taken);
    bht_old    = bht[ex_idx];
    bht_new    = bht_old;
    if (actual) begin
      if (bht_old != 2'b11) bht_new = bht_old + 2'd1;
    end else begin
      if (bht_old != 2'b00) bht_new = bht_old - 2'd1;
    end
  end

  // Next-state and registered-output values.
  always_comb begin
    state_d       = state_q;
    fcnt_d        = fcnt_q;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc;
    cnt_d         = mispredict_cnt;
    case (state_q)
      S_IDLE: begin
        if (mispredict) begin
          state_d       = S_FLUSH;
          fcnt_d        = FC_W'(FLUSH_CYCLES);
          redirect_d    = 1'b1;
          redirect_pc_d = actual ? ex_target : (ex_pc + 32'd4);
          if (mispredict_cnt != {CNT_W{1'b1}}) cnt_d = mispredict_cnt + CNT_W'(1);
        end
      end
      S_FLUSH: begin
        fcnt_d = fcnt_q - FC_W'(1);
        if (fcnt_q <= FC_W'(1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    flush_d = (state_d == S_FLUSH);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= S_IDLE;
      fcnt_q         <= '0;
      redirect       <= 1'b0;
      redirect_pc    <= '0;
      flush          <= 1'b0;
      mispredict_cnt <= '0;
      for (int i = 0; i < int'(DEPTH); i++) bht[i] <= 2'b01;
    end else begin
      state_q        <= state_d;
      fcnt_q         <= fcnt_d;
      redirect       <= redirect_d;
      redirect_pc    <= redirect_pc_d;
      flush          <= flush_d;
      mispredict_cnt <= cnt_d;
      if (resolve) bht[ex_idx] <= bht_new;
    end
  end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Self-checking bench for branch_predict_ctrl: directed vector table, a short
// address-wrap sequence, then random traffic against a behavioural model.
module tb_branch_predict_ctrl;

  localparam int NFLUSH = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic        stall_in;
  logic        ex_valid;
  logic [1:0]  ex_branch;
  logic        ex_zero;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [15:0] mispredict_cnt;

  branch_predict_ctrl #(.IDX_BITS(6), .FLUSH_CYCLES(NFLUSH), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .if_pc(if_pc), .pred_taken(pred_taken),
    .stall_in(stall_in), .ex_valid(ex_valid), .ex_branch(ex_branch),
    .ex_zero(ex_zero), .ex_pc(ex_pc), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .redirect(redirect),
    .redirect_pc(redirect_pc), .flush(flush), .mispredict_cnt(mispredict_cnt)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Behavioural model: counters as integers, flush as remaining-cycle budget.
  int          bht_m [64];
  int          flush_rem;
  int          cnt_m;
  logic        red_m;
  logic [31:0] rpc_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  task automatic model_step();
    bit act;
    int i;
    if (reset) begin
      for (int k = 0; k < 64; k++) bht_m[k] = 1;
      flush_rem = 0; cnt_m = 0; red_m = 1'b0; rpc_m = 32'h0;
      return;
    end
    red_m = 1'b0;
    if (flush_rem > 0) begin
      flush_rem--;
    end else if (ex_valid && !stall_in && (ex_branch == 2'b11 || ex_branch == 2'b01)) begin
      act = (ex_branch == 2'b11) ? ex_zero : !ex_zero;
      i = idx_of(ex_pc);
      bht_m[i] = act ? ((bht_m[i] + 1 > 3) ? 3 : bht_m[i] + 1)
                     : ((bht_m[i] - 1 < 0) ? 0 : bht_m[i] - 1);
      if (act != ex_pred_taken) begin
        red_m = 1'b1;
        rpc_m = act ? ex_target : ex_pc + 32'd4;
        flush_rem = NFLUSH;
        if (cnt_m < 65535) cnt_m++;
      end
    end
  endtask

  // One clock: model consumes the inputs the DUT samples, then settle past the edge.
  task automatic step();
    model_step();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic [31:0] ifpc;
    logic        v;
    logic [1:0]  br;
    logic        z;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        pr;
    logic        st;
    logic        e_red;
    logic        e_fl;
    int          e_cnt;
    logic        e_pred;
    logic        c_rpc;
    logic [31:0] e_rpc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic [31:0] ifpc, input logic v,
                              input logic [1:0] br, input logic z, input logic [31:0] pc,
                              input logic pr, input logic st, input logic e_red,
                              input logic e_fl, input int e_cnt, input logic e_pred,
                              input logic c_rpc, input logic [31:0] e_rpc);
    vec_t r;
    r.rst = rst; r.ifpc = ifpc; r.v = v; r.br = br; r.z = z; r.pc = pc;
    r.tgt = 32'h80; r.pr = pr; r.st = st; r.e_red = e_red; r.e_fl = e_fl;
    r.e_cnt = e_cnt; r.e_pred = e_pred; r.c_rpc = c_rpc; r.e_rpc = e_rpc;
    return r;
  endfunction

  task automatic drive(input logic rst, input logic [31:0] ifpc, input logic v,
                       input logic [1:0] br, input logic z, input logic [31:0] pc,
                       input logic [31:0] tgt, input logic pr, input logic st);
    reset = rst; if_pc = ifpc; ex_valid = v; ex_branch = br; ex_zero = z;
    ex_pc = pc; ex_target = tgt; ex_pred_taken = pr; stall_in = st;
  endtask

  initial begin
    drive(1'b1, 32'h40, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    //            rst ifpc    v  br    z  pc      pr st  red fl cnt pred crpc rpc
    tbl.push_back(mk(1, 32'h40, 0, 2'b00, 0, 32'h0,  0, 0,  0, 0, 0, 0, 1, 32'h0));
    tbl.push_back(mk(0, 32'h40, 0, 2'b00, 0, 32'h0,  0, 0,  0, 0, 0, 0, 1, 32'h0));
    tbl.push_back(mk(0, 32'h40, 1, 2'b11, 1, 32'h40, 0, 0,  1, 1, 1, 1, 1, 32'h80));
    tbl.push_back(mk(0, 32'h40, 0, 2'b00, 0, 32'h0,  0, 0,  0, 1, 1, 1, 0, 32'h0));
    tbl.push_back(mk(0, 32'h40, 0, 2'b00, 0, 32'h0,  0, 0,  0, 0, 1, 1, 0, 32'h0));
    tbl.push_back(mk(0, 32'h44, 1, 2'b01, 1, 32'h44, 1, 0,  1, 1, 2, 0, 1, 32'h48));
    tbl.push_back(mk(0, 32'h44, 0, 2'b00, 0, 32'h0,  0, 0,  0, 1, 2, 0, 0, 32'h0));
    tbl.push_back(mk(0, 32'h44, 0, 2'b00, 0, 32'h0,  0, 0,  0, 0, 2, 0, 0, 32'h0));
    tbl.push_back(mk(0, 32'h40, 1, 2'b11, 1, 32'h40, 1, 0,  0, 0, 2, 1, 0, 32'h0));
    tbl.push_back(mk(0, 32'h40, 1, 2'b11, 1, 32'h40, 1, 0,  0, 0, 2, 1, 0, 32'h0));
    tbl.push_back(mk(0, 32'h40, 1, 2'b11, 0, 32'h40, 1, 0,  1, 1, 3, 1, 1, 32'h44));
    tbl.push_back(mk(0, 32'h40, 0, 2'b00, 0, 32'h0,  0, 0,  0, 1, 3, 1, 0, 32'h0));
    tbl.push_back(mk(0, 32'h40, 1, 2'b11, 0, 32'h40, 1, 0,  0, 0, 3, 1, 0, 32'h0));
    tbl.push_back(mk(0, 32'h40, 0, 2'b00, 0, 32'h0,  0, 0,  0, 0, 3, 1, 0, 32'h0));
    tbl.push_back(mk(0, 32'h40, 1, 2'b11, 0, 32'h40, 0, 1,  0, 0, 3, 1, 0, 32'h0));
    tbl.push_back(mk(0, 32'h40, 1, 2'b11, 0, 32'h40, 0, 1,  0, 0, 3, 1, 0, 32'h0));
    tbl.push_back(mk(0, 32'h40, 1, 2'b11, 0, 32'h40, 0, 1,  0, 0, 3, 1, 0, 32'h0));
    tbl.push_back(mk(0, 32'h40, 1, 2'b11, 0, 32'h40, 0, 0,  0, 0, 3, 0, 0, 32'h0));
    tbl.push_back(mk(0, 32'h40, 0, 2'b00, 0, 32'h0,  0, 0,  0, 0, 3, 0, 0, 32'h0));
    tbl.push_back(mk(0, 32'h40, 1, 2'b11, 1, 32'h40, 1, 0,  0, 0, 3, 1, 0, 32'h0));
    tbl.push_back(mk(0, 32'h40, 0, 2'b00, 0, 32'h0,  0, 0,  0, 0, 3, 1, 0, 32'h0));
    tbl.push_back(mk(0, 32'h40, 1, 2'b01, 1, 32'h48, 1, 0,  1, 1, 4, 1, 1, 32'h4c));
    tbl.push_back(mk(0, 32'h40, 0, 2'b00, 0, 32'h0,  0, 0,  0, 1, 4, 1, 0, 32'h0));
    tbl.push_back(mk(1, 32'h40, 0, 2'b00, 0, 32'h0,  0, 0,  0, 0, 0, 0, 1, 32'h0));
    tbl.push_back(mk(0, 32'h40, 0, 2'b00, 0, 32'h0,  0, 0,  0, 0, 0, 0, 1, 32'h0));
    tbl.push_back(mk(0, 32'h40, 1, 2'b10, 1, 32'h40, 0, 0,  0, 0, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 32'h40, 1, 2'b00, 1, 32'h40, 0, 0,  0, 0, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 32'h40, 1, 2'b11, 1, 32'h40, 0, 0,  1, 1, 1, 1, 1, 32'h80));

    for (int r = 0; r < tbl.size(); r++) begin
      drive(tbl[r].rst, tbl[r].ifpc, tbl[r].v, tbl[r].br, tbl[r].z, tbl[r].pc,
            tbl[r].tgt, tbl[r].pr, tbl[r].st);
      step();
      chk($sformatf("vec%0d redirect", r), 32'(redirect), 32'(tbl[r].e_red));
      chk($sformatf("vec%0d flush", r), 32'(flush), 32'(tbl[r].e_fl));
      chk($sformatf("vec%0d cnt", r), 32'(mispredict_cnt), 32'(tbl[r].e_cnt));
      chk($sformatf("vec%0d pred", r), 32'(pred_taken), 32'(tbl[r].e_pred));
      if (tbl[r].c_rpc) chk($sformatf("vec%0d rpc", r), redirect_pc, tbl[r].e_rpc);
    end

    // Fall-through address wraps modulo 2**32.
    drive(1'b0, 32'h0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    for (int k = 0; k < NFLUSH; k++) step();
    drive(1'b0, 32'hFFFF_FFFC, 1'b1, 2'b01, 1'b1, 32'hFFFF_FFFC, 32'h1000, 1'b1, 1'b0);
    step();
    chk("wrap redirect", 32'(redirect), 32'h1);
    chk("wrap rpc", redirect_pc, 32'h0);
    chk("wrap cnt", 32'(mispredict_cnt), 32'd2);

    // Random traffic against the model.
    drive(1'b1, 32'h0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    for (int c = 0; c < 3000; c++) begin
      drive(($urandom_range(0, 299) == 0),
            ($urandom_range(0, 15) << 2) | ($urandom_range(0, 1) << 20),
            1'($urandom), 2'($urandom), 1'($urandom),
            ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC
                                        : (($urandom_range(0, 15) << 2) | 32'h0000_1000),
            $urandom, 1'($urandom), ($urandom_range(0, 3) == 0));
      step();
      chk("rnd redirect", 32'(redirect), 32'(red_m));
      chk("rnd flush", 32'(flush), 32'(flush_rem > 0));
      chk("rnd cnt", 32'(mispredict_cnt), 32'(cnt_m));
      chk("rnd pred", 32'(pred_taken), 32'(bht_m[idx_of(if_pc)] >= 2));
      if (red_m || reset) chk("rnd rpc", redirect_pc, rpc_m);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
